// File: rtl/jk_drv_pkg.sv
// Shared types and the per-bit JK excitation rule for the excitation driver.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Returns {j, k} that moves one JK flop from s to t; dc fills the free input.
  function automatic logic [1:0] jk_excite(input logic s, input logic t, input logic dc);
    logic [1:0] jk;
    case ({s, t})
      2'b00:   jk = {1'b0, dc};
      2'b01:   jk = 2'b10;
      2'b10:   jk = 2'b01;
      default: jk = {dc, 1'b0};
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// Target word FIFO; pointers carry a wrap bit so full/empty fall out of a compare.
module jk_tgt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; push is refused when full, pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flop bank toward queued target words and checks its feedback.
//   state | meaning
//   IDLE  | j=k=0, waiting for a queued target
//   DRIVE | j/k carry excitation for one cycle, bank captures at closing edge
//   CHECK | q_fb compared against the target, mismatches made sticky
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int   WIDTH  = 8,
  parameter int   DEPTH  = 4,
  parameter logic DC_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             drv_valid,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  input  logic             clr_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             drv_valid_q, drv_valid_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_bits_q, err_bits_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic [WIDTH-1:0] exc_j, exc_k;
  logic [WIDTH-1:0] mism;

  assign fifo_push = tgt_valid && !fifo_full;
  assign tgt_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign drv_valid = drv_valid_q;
  assign err       = err_q;
  assign err_bits  = err_bits_q;
  assign mism      = q_fb ^ tgt_q;

  jk_tgt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (tgt_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Excitation for the FIFO head against the commanded (shadow) bank state.
  always_comb begin
    exc_j = '0;
    exc_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {exc_j[i], exc_k[i]} = jk_excite(shadow_q[i], fifo_dout[i], DC_VAL);
    end
  end

  // Next-state logic; clr_err is applied first so a fresh mismatch overrides it.
  always_comb begin
    state_d     = state_q;
    j_d         = '0;
    k_d         = '0;
    drv_valid_d = 1'b0;
    tgt_d       = tgt_q;
    shadow_d    = shadow_q;
    err_d       = clr_err ? 1'b0 : err_q;
    err_bits_d  = clr_err ? '0 : err_bits_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          j_d         = exc_j;
          k_d         = exc_k;
          drv_valid_d = 1'b1;
          tgt_d       = fifo_dout;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        shadow_d = tgt_q;
        state_d  = CHECK;
      end
      CHECK: begin
        err_bits_d = (clr_err ? '0 : err_bits_q) | mism;
        err_d      = (clr_err ? 1'b0 : err_q) | (|mism);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered outputs; async reset drops j/k without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      j_q         <= '0;
      k_q         <= '0;
      drv_valid_q <= 1'b0;
      tgt_q       <= '0;
      shadow_q    <= '0;
      err_q       <= 1'b0;
      err_bits_q  <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      k_q         <= k_d;
      drv_valid_q <= drv_valid_d;
      tgt_q       <= tgt_d;
      shadow_q    <= shadow_d;
      err_q       <= err_d;
      err_bits_q  <= err_bits_d;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with behavioural JK bank models.
module tb_jk_excitation_driver;

  logic       clk;
  logic       reset;

  logic       tgt_valid, tgt_ready, drv_valid, busy, err, clr_err;
  logic [7:0] tgt_data, q_fb, j, k, err_bits, bank0, fault0;

  logic       tgt_valid1, tgt_ready1, drv_valid1, busy1, err1, clr_err1;
  logic [7:0] tgt_data1, q_fb1, j1, k1, err_bits1, bank1;

  int n_checks = 0;
  int n_errors = 0;

  jk_excitation_driver #(.WIDTH(8), .DEPTH(4), .DC_VAL(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_data(tgt_data), .q_fb(q_fb), .j(j), .k(k), .drv_valid(drv_valid),
    .busy(busy), .err(err), .err_bits(err_bits), .clr_err(clr_err)
  );

  jk_excitation_driver #(.WIDTH(8), .DEPTH(4), .DC_VAL(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid1), .tgt_ready(tgt_ready1),
    .tgt_data(tgt_data1), .q_fb(q_fb1), .j(j1), .k(k1), .drv_valid(drv_valid1),
    .busy(busy1), .err(err1), .err_bits(err_bits1), .clr_err(clr_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank models, reset by the same reset as the driver.
  always @(posedge clk or negedge reset) begin
    if (!reset) bank0 <= '0;
    else        bank0 <= (j & ~bank0) | (~k & bank0);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) bank1 <= '0;
    else        bank1 <= (j1 & ~bank1) | (~k1 & bank1);
  end

  assign q_fb  = bank0 ^ fault0;
  assign q_fb1 = bank1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [7:0] d);
    tgt_valid = 1'b1;
    tgt_data  = d;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
  endtask

  task automatic push1(input logic [7:0] d);
    tgt_valid1 = 1'b1;
    tgt_data1  = d;
    @(posedge clk);
    #1;
    tgt_valid1 = 1'b0;
  endtask

  task automatic wait_drv(input bit sel, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = sel ? drv_valid1 : drv_valid;
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    bit idle = 1'b0;
    for (int n = 0; n < 20 && !idle; n++) begin
      @(negedge clk);
      idle = sel ? !busy1 : !busy;
    end
    chk(tag, idle, 1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] w5 [8];
  logic [7:0] w6 [5];

  initial begin
    logic [7:0] m_shadow;
    int cnt, idx, pop_idx, n_drv;
    bit push_prev, saw_full;

    w5 = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h0F, 8'hF0, 8'h3C, 8'hC3};
    w6 = '{8'h00, 8'hFF, 8'h11, 8'h22, 8'h33};

    reset = 1'b0;
    tgt_valid = 1'b0; tgt_data = '0; clr_err = 1'b0; fault0 = '0;
    tgt_valid1 = 1'b0; tgt_data1 = '0; clr_err1 = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_j", j, 8'h00);
    chk("rst_k", k, 8'h00);
    chk("rst_drv_valid", drv_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_err_bits", err_bits, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tgt_ready, 1);
    reset = 1'b1;

    // 1: first target, two-edge latency
    push0(8'hA5);
    @(negedge clk);
    chk("t1_lat_edge1", drv_valid, 0);
    @(negedge clk);
    chk("t1_lat_edge2", drv_valid, 1);
    chk("t1_j", j, 8'hA5);
    chk("t1_k", k, 8'h00);
    wait_idle(0, "t1_idle");
    chk("t1_err", err, 0);

    // 2: full toggle, then repeat of the same target
    push0(8'h5A);
    wait_drv(0, "t2a_drv");
    chk("t2a_j", j, 8'h5A);
    chk("t2a_k", k, 8'hA5);
    wait_idle(0, "t2a_idle");
    push0(8'h5A);
    wait_drv(0, "t2b_drv");
    chk("t2b_j", j, 8'h00);
    chk("t2b_k", k, 8'h00);
    wait_idle(0, "t2b_idle");
    chk("t2_err", err, 0);

    // 3: DC_VAL=1 instance
    push1(8'h0F);
    wait_drv(1, "t3a_drv");
    chk("t3a_j", j1, 8'h0F);
    chk("t3a_k", k1, 8'hF0);
    wait_idle(1, "t3a_idle");
    push1(8'h0F);
    wait_drv(1, "t3b_drv");
    chk("t3b_j", j1, 8'h0F);
    chk("t3b_k", k1, 8'hF0);
    wait_idle(1, "t3b_idle");
    chk("t3_err", err1, 0);

    // 4: faulted feedback, clear, and clear colliding with a new mismatch
    fault0 = 8'h01;
    push0(8'h5A);
    wait_drv(0, "t4a_drv");
    chk("t4a_j", j, 8'h00);
    chk("t4a_k", k, 8'h00);
    wait_idle(0, "t4a_idle");
    chk("t4a_err", err, 1);
    chk("t4a_err_bits", err_bits, 8'h01);
    fault0 = 8'h00;
    pulse_clr();
    chk("t4b_err", err, 0);
    chk("t4b_err_bits", err_bits, 8'h00);
    fault0 = 8'h01;
    push0(8'h5A);
    wait_idle(0, "t4c_idle");
    chk("t4c_err_bits", err_bits, 8'h01);
    fault0 = 8'h80;
    push0(8'h5A);
    wait_drv(0, "t4d_drv");
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("t4d_err", err, 1);
    chk("t4d_err_bits", err_bits, 8'h80);
    fault0 = 8'h00;
    pulse_clr();
    chk("t4e_err", err, 0);

    // 5: eight back-to-back words with valid held
    m_shadow = 8'h5A;
    cnt = 0; idx = 0; pop_idx = 0; n_drv = 0; push_prev = 1'b0; saw_full = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cnt = cnt + (push_prev ? 1 : 0) - (drv_valid ? 1 : 0);
      if (drv_valid) begin
        n_drv++;
        if (pop_idx < 8) begin
          chk("t5_j", j, w5[pop_idx] & ~m_shadow);
          chk("t5_k", k, m_shadow & ~w5[pop_idx]);
          m_shadow = w5[pop_idx];
          pop_idx++;
        end
      end
      chk("t5_ready", tgt_ready, (cnt < 4) ? 1 : 0);
      if (!tgt_ready) saw_full = 1'b1;
      tgt_valid = (idx < 8);
      tgt_data  = (idx < 8) ? w5[idx] : 8'h00;
      push_prev = tgt_valid && tgt_ready;
      if (push_prev) idx++;
      if (n_drv >= 8 && idx >= 8) break;
    end
    tgt_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (drv_valid) n_drv++;
    end
    chk("t5_pushed", idx, 8);
    chk("t5_drv_count", n_drv, 8);
    chk("t5_saw_full", saw_full, 1);
    chk("t5_busy", busy, 0);
    chk("t5_err", err, 0);

    // 6: reset in the middle of DRIVE with three words queued
    for (int i = 0; i < 5; i++) begin
      tgt_valid = 1'b1;
      tgt_data  = w6[i];
      @(posedge clk);
      #1;
    end
    tgt_valid = 1'b0;
    @(negedge clk);
    chk("t6_in_drive", drv_valid, 1);
    chk("t6_j_pre", j, 8'hFF);
    reset = 1'b0;
    #1;
    chk("t6_j_async", j, 8'h00);
    chk("t6_k_async", k, 8'h00);
    chk("t6_drv_async", drv_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", tgt_ready, 1);
    chk("t6_err", err, 0);
    n_drv = 0;
    repeat (30) begin
      @(negedge clk);
      if (drv_valid) n_drv++;
    end
    chk("t6_no_drive", n_drv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
